fifo_rr_drain_arbiter: RTL and testbench

- Moves words from NumSources upstream FIFO read ports into one downstream FIFO write port.
- Shares the downstream FIFO between sources using round-robin, with at most Burst words per grant.
- Sits between per-requester fifo / cdc_fifo instances and a shared sink FIFO. It speaks the native FIFO handshakes on both sides:
  - upstream: read_valid / read_req, with data registered one cycle after read_req;
  - downstream: write_valid / write_req, with data sampled on the write_req edge.

---
 rtl/fifo_rr_drain_arbiter.sv | 138 +++++++++++++
 tb/tb_fifo_rr_drain_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain_arbiter.sv
// Drains NumSources upstream FIFO read ports into one downstream FIFO write port.
// Sources are served round-robin, with at most Burst words moved per grant.
module fifo_rr_drain_arbiter #(
  parameter int NumSources = 4,
  parameter int Width      = 8,
  parameter int Burst      = 4,
  localparam int GW        = $clog2(NumSources),
  localparam int CW        = $clog2(Burst + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumSources-1:0]       enable_i,
  input  logic [NumSources-1:0]       read_valid_i,
  output logic [NumSources-1:0]       read_req_o,
  input  logic [NumSources*Width-1:0] data_i,
  input  logic                        write_valid_i,
  output logic                        write_req_o,
  output logic [Width-1:0]            data_o,
  output logic [GW-1:0]               grant_o,
  output logic                        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [GW-1:0]     r_grant;
  logic [GW-1:0]     w_next_grant;
  logic [GW-1:0]     r_last_grant;
  logic [GW-1:0]     w_next_last_grant;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_next_count;
  logic [CW-1:0]     w_count_inc;
  logic [NumSources-1:0] w_eligible;
  logic [GW-1:0]     w_scan_idx;
  logic [GW-1:0]     w_rr_pick;
  logic              w_any_eligible;
  logic              w_src_ok;
  logic [Width-1:0]  w_src_data [NumSources];

  for (genvar g = 0; g < NumSources; g++) begin : g_slice
    assign w_src_data[g] = data_i[g*Width +: Width];
  end

  assign w_eligible  = read_valid_i & enable_i;
  assign w_src_ok    = read_valid_i[r_grant] & enable_i[r_grant];
  assign w_count_inc = r_count + 1'b1;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state != S_IDLE);

  // Round-robin pick: walk last_grant+1, +2, ... with wrap; the first eligible hit wins.
  always_comb begin
    w_scan_idx     = r_last_grant;
    w_rr_pick      = '0;
    w_any_eligible = 1'b0;
    for (int i = 0; i < NumSources; i++) begin
      if (w_scan_idx == GW'(NumSources - 1)) begin
        w_scan_idx = '0;
      end else begin
        w_scan_idx = w_scan_idx + 1'b1;
      end
      if (!w_any_eligible && w_eligible[w_scan_idx]) begin
        w_rr_pick      = w_scan_idx;
        w_any_eligible = 1'b1;
      end else begin
        w_any_eligible = w_any_eligible;
      end
    end
  end

  // Next-state and strobe logic.
  always_comb begin
    w_next_state      = r_state;
    w_next_grant      = r_grant;
    w_next_last_grant = r_last_grant;
    w_next_count      = r_count;
    read_req_o        = '0;
    write_req_o       = 1'b0;
    data_o            = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any_eligible) begin
          w_next_grant = w_rr_pick;
          w_next_count = '0;
          w_next_state = S_READ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_READ: begin
        if (w_src_ok && write_valid_i) begin
          read_req_o[r_grant] = 1'b1;
          w_next_state        = S_WRITE;
        end else if (!w_src_ok) begin
          w_next_last_grant = r_grant;
          w_next_state      = S_IDLE;
        end else begin
          w_next_state = S_READ;
        end
      end
      S_WRITE: begin
        // The word popped in READ is on the source's data lane this cycle.
        write_req_o  = 1'b1;
        data_o       = w_src_data[r_grant];
        w_next_count = w_count_inc;
        if (w_count_inc == CW'(Burst)) begin
          w_next_last_grant = r_grant;
          w_next_state      = S_IDLE;
        end else begin
          w_next_state = S_READ;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State registers; last_grant resets to the top index so source 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NumSources - 1);
      r_count      <= '0;
    end else begin
      r_state      <= w_next_state;
      r_grant      <= w_next_grant;
      r_last_grant <= w_next_last_grant;
      r_count      <= w_next_count;
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Directed self-checking bench: behavioural upstream FIFOs and a logging sink
// wrap the arbiter; each task drives one scenario and checks hand-computed values.
module tb_fifo_rr_drain_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic [N-1:0]   enable_i = 4'b1111;
  logic [N-1:0]   read_valid_i = 4'b0000;
  logic [N-1:0]   read_req_o;
  logic [N*W-1:0] data_i = '0;
  logic           write_valid_i = 1'b1;
  logic           write_req_o;
  logic [W-1:0]   data_o;
  logic [1:0]     grant_o;
  logic           busy_o;

  int n_pass = 0;
  int n_total = 0;

  logic [W-1:0] src_mem [N][64];
  int           head [N];
  int           tail [N];
  logic [W-1:0] sink_data [256];
  logic [1:0]   sink_grant [256];
  int           sink_n = 0;

  fifo_rr_drain_arbiter #(.NumSources(N), .Width(W), .Burst(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .read_valid_i(read_valid_i),
    .read_req_o(read_req_o), .data_i(data_i), .write_valid_i(write_valid_i),
    .write_req_o(write_req_o), .data_o(data_o), .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // FIFO models: observe strobes mid-cycle, apply pop/push just after the edge.
  initial begin
    logic [N-1:0] cap_rr;
    logic         cap_wr;
    logic [W-1:0] cap_d;
    logic [1:0]   cap_g;
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    forever begin
      @(negedge clk);
      #2;
      cap_rr = read_req_o;
      cap_wr = write_req_o;
      cap_d  = data_o;
      cap_g  = grant_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (cap_rr[k] && head[k] < tail[k]) begin
          data_i[k*W +: W] = src_mem[k][head[k]];
          head[k] = head[k] + 1;
        end
        read_valid_i[k] = (head[k] < tail[k]);
      end
      if (cap_wr && sink_n < 256) begin
        sink_data[sink_n]  = cap_d;
        sink_grant[sink_n] = cap_g;
        sink_n = sink_n + 1;
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push(input int k, input logic [W-1:0] v);
    src_mem[k][tail[k]] = v;
    tail[k] = tail[k] + 1;
    read_valid_i[k] = 1'b1;
  endtask

  task automatic flush();
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    read_valid_i = '0;
    sink_n = 0;
  endtask

  task automatic do_reset();
    cyc();
    rst_i = 1'b1;
    enable_i = 4'b1111;
    write_valid_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
    flush();
  endtask

  task automatic wait_sink(input int n, input string name);
    int c = 0;
    while (sink_n < n && c < 600) begin
      cyc();
      c++;
    end
    n_total++;
    if (sink_n < n) $display("FAIL %s timeout: got %0d words, expected %0d", name, sink_n, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_total++;
      if ({busy_o, read_req_o, write_req_o} !== 6'b0)
        $display("FAIL reset_idle cyc%0d: busy/rr/wr=%b expected 000000", i, {busy_o, read_req_o, write_req_o});
      else n_pass++;
    end
    n_total++;
    if ({grant_o, data_o} !== 10'h000) $display("FAIL reset_outputs: grant/data=%h expected 000", {grant_o, data_o});
    else n_pass++;
  endtask

  task automatic test_single_word();
    push(2, 8'hAB);
    cyc();
    n_total++;
    if ({read_req_o, write_req_o} !== 5'b0100_0) $display("FAIL single_read: rr/wr=%b expected 01000", {read_req_o, write_req_o});
    else n_pass++;
    cyc();
    n_total++;
    if ({read_req_o, write_req_o, data_o} !== {4'b0000, 1'b1, 8'hAB})
      $display("FAIL single_write: rr/wr/data=%b/%b/%h expected 0000/1/ab", read_req_o, write_req_o, data_o);
    else n_pass++;
    cyc();
    cyc();
    n_total++;
    if ({busy_o, grant_o} !== {1'b0, 2'd2}) $display("FAIL single_idle: busy/grant=%b/%0d expected 0/2", busy_o, grant_o);
    else n_pass++;
  endtask

  task automatic test_two_sources();
    logic [7:0] exp_d [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13, 8'h04, 8'h05, 8'h14, 8'h15};
    logic [1:0] exp_g [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
    sink_n = 0;
    for (int i = 0; i < 6; i++) begin
      push(0, 8'(i));
      push(1, 8'(8'h10 + i));
    end
    wait_sink(12, "two_src");
    for (int j = 0; j < 12; j++) begin
      n_total++;
      if ({sink_grant[j], sink_data[j]} !== {exp_g[j], exp_d[j]})
        $display("FAIL two_src word%0d: grant/data=%0d/%h expected %0d/%h", j, sink_grant[j], sink_data[j], exp_g[j], exp_d[j]);
      else n_pass++;
    end
    repeat (6) cyc();
    n_total++;
    if (sink_n !== 12) $display("FAIL two_src_count: got %0d words expected 12", sink_n);
    else n_pass++;
  endtask

  task automatic test_all_sources();
    int c = 0;
    do_reset();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 8; i++) push(k, 8'(k*16 + i));
    while (sink_n < 20 && c < 600) begin
      cyc();
      c++;
      n_total++;
      if (!$onehot0(read_req_o) || (|read_req_o && write_req_o))
        $display("FAIL all_strobes cyc%0d: rr=%b wr=%b", c, read_req_o, write_req_o);
      else n_pass++;
    end
    n_total++;
    if (sink_n < 20) $display("FAIL all_src timeout: got %0d words expected 20", sink_n);
    else n_pass++;
    for (int j = 0; j < 20; j++) begin
      logic [1:0] eg;
      logic [7:0] ed;
      eg = 2'((j / 4) % 4);
      ed = 8'(int'(eg) * 16 + (j / 16) * 4 + j % 4);
      n_total++;
      if ({sink_grant[j], sink_data[j]} !== {eg, ed})
        $display("FAIL all_src word%0d: grant/data=%0d/%h expected %0d/%h", j, sink_grant[j], sink_data[j], eg, ed);
      else n_pass++;
    end
  endtask

  task automatic test_downstream_full();
    do_reset();
    push(0, 8'h40);
    push(0, 8'h41);
    push(0, 8'h42);
    wait_sink(1, "full_first");
    write_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_total++;
      if ({busy_o, read_req_o, write_req_o} !== 6'b1_0000_0)
        $display("FAIL full_stall cyc%0d: busy/rr/wr=%b expected 100000", i, {busy_o, read_req_o, write_req_o});
      else n_pass++;
    end
    write_valid_i = 1'b1;
    wait_sink(3, "full_release");
    repeat (6) cyc();
    n_total++;
    if ({sink_n[7:0], sink_data[0], sink_data[1], sink_data[2]} !== {8'd3, 8'h40, 8'h41, 8'h42})
      $display("FAIL full_data: n=%0d data=%h %h %h expected 3 40 41 42", sink_n, sink_data[0], sink_data[1], sink_data[2]);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    logic [7:0] exp_d [9] = '{8'h50, 8'h60, 8'h61, 8'h62, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    int c = 0;
    do_reset();
    for (int i = 0; i < 6; i++) push(1, 8'(8'h50 + i));
    for (int i = 0; i < 3; i++) push(2, 8'(8'h60 + i));
    cyc();
    while (!write_req_o && c < 20) begin
      cyc();
      c++;
    end
    n_total++;
    if ({write_req_o, grant_o, data_o} !== {1'b1, 2'd1, 8'h50})
      $display("FAIL en_first: wr/grant/data=%b/%0d/%h expected 1/1/50", write_req_o, grant_o, data_o);
    else n_pass++;
    enable_i = 4'b1101;
    wait_sink(4, "en_disabled");
    repeat (8) cyc();
    n_total++;
    if (sink_n !== 4) $display("FAIL en_no_pop: got %0d words expected 4", sink_n);
    else n_pass++;
    enable_i = 4'b1111;
    wait_sink(9, "en_reenabled");
    for (int j = 0; j < 9; j++) begin
      n_total++;
      if (sink_data[j] !== exp_d[j]) $display("FAIL en_order word%0d: got %h expected %h", j, sink_data[j], exp_d[j]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_write();
    int c = 0;
    do_reset();
    push(3, 8'h70);
    push(3, 8'h71);
    cyc();
    while (!write_req_o && c < 20) begin
      cyc();
      c++;
    end
    n_total++;
    if ({write_req_o, grant_o} !== {1'b1, 2'd3}) $display("FAIL rstw_write: wr/grant=%b/%0d expected 1/3", write_req_o, grant_o);
    else n_pass++;
    rst_i = 1'b1;
    cyc();
    n_total++;
    if ({busy_o, read_req_o, write_req_o, grant_o, data_o} !== 16'h0000)
      $display("FAIL rstw_outputs: busy/rr/wr/grant/data=%b/%b/%b/%0d/%h expected all 0", busy_o, read_req_o, write_req_o, grant_o, data_o);
    else n_pass++;
    rst_i = 1'b0;
    flush();
    push(0, 8'h80);
    push(1, 8'h81);
    push(3, 8'h83);
    wait_sink(3, "rstw_after");
    n_total++;
    if ({sink_grant[0], sink_data[0], sink_grant[1], sink_data[1], sink_grant[2], sink_data[2]}
        !== {2'd0, 8'h80, 2'd1, 8'h81, 2'd3, 8'h83})
      $display("FAIL rstw_order: %0d/%h %0d/%h %0d/%h expected 0/80 1/81 3/83", sink_grant[0], sink_data[0],
               sink_grant[1], sink_data[1], sink_grant[2], sink_data[2]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_sources();
    test_all_sources();
    test_downstream_full();
    test_enable_drop();
    test_reset_in_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
